fsm_oe4s_sequencer: RTL and testbench

FSM_OE4S_SEQUENCER -- requirements
Module: fsm_oe4s_sequencer

---
 rtl/fsm_oe4s_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fsm_oe4s_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_oe4s_sequencer.sv
// Route sequencer for a one-hot 4-state FSM: steps the driven FSM through a
// programmable list of target states, checks the one-hot feedback after every
// move and optionally dwells a programmable number of cycles per step.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cfg_we/addr/state/dwell route-table write port (accepted only while idle)
//   route_len              index of the last route step, latched on start
//   start, abort           level-sampled control requests
//   st0..st3               one-hot state feedback from the driven FSM
//   t0x..t3x               transition selects to the driven FSM
//   busy, done, err        status (done one-cycle pulse, err sticky)
//   step_idx               current route step index
module fsm_oe4s_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [1:0] cfg_state,
    input  logic [3:0] cfg_dwell,
    input  logic [2:0] route_len,
    input  logic       start,
    input  logic       abort,
    input  logic       st0,
    input  logic       st1,
    input  logic       st2,
    input  logic       st3,
    output logic [1:0] t0x,
    output logic [1:0] t1x,
    output logic [1:0] t2x,
    output logic [1:0] t3x,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] step_idx
);

    localparam int unsigned STEP_W  = 3;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned DWELL_W = 4;
    localparam int unsigned ENTRIES = 8;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, DWELL} seq_state_t;

    seq_state_t           state, state_next;
    logic [STATE_W-1:0]   route_state [ENTRIES];
    logic [DWELL_W-1:0]   route_dwell [ENTRIES];
    logic [STEP_W-1:0]    len_q, len_next;
    logic [DWELL_W-1:0]   cnt_q, cnt_next;
    logic [STEP_W-1:0]    step_next;
    logic                 err_next, done_next, busy_next;
    logic [STATE_W-1:0]   cur_target, tgt_next;
    logic [DWELL_W-1:0]   cur_dwell;
    logic [3:0]           fb, fb_expect;
    logic                 fb_ok, advance, we_ok;
    logic [STATE_W-1:0]   t0_next, t1_next, t2_next, t3_next;

    // State register plus all registered outputs and the route table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            step_idx <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            t0x      <= 2'd0;
            t1x      <= 2'd1;
            t2x      <= 2'd2;
            t3x      <= 2'd3;
            for (int i = 0; i < ENTRIES; i++) begin
                route_state[i] <= '0;
                route_dwell[i] <= '0;
            end
        end else begin
            state    <= state_next;
            len_q    <= len_next;
            cnt_q    <= cnt_next;
            step_idx <= step_next;
            err      <= err_next;
            done     <= done_next;
            busy     <= busy_next;
            t0x      <= t0_next;
            t1x      <= t1_next;
            t2x      <= t2_next;
            t3x      <= t3_next;
            if (we_ok) begin
                route_state[cfg_addr] <= cfg_state;
                route_dwell[cfg_addr] <= cfg_dwell;
            end
        end
    end

    // Next-state logic; outputs are computed from the next state so they
    // line up with the state they describe
    always_comb begin
        state_next = state;
        len_next   = len_q;
        cnt_next   = cnt_q;
        step_next  = step_idx;
        err_next   = err;
        done_next  = 1'b0;
        advance    = 1'b0;

        we_ok      = cfg_we && (state == IDLE);
        cur_target = route_state[step_idx];
        cur_dwell  = route_dwell[step_idx];
        fb         = {st3, st2, st1, st0};
        fb_expect  = 4'b0001 << cur_target;
        // Exact compare rejects zero, multi-hot and wrong-state feedback
        fb_ok      = (fb == fb_expect);

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = MOVE;
                    step_next  = '0;
                    len_next   = route_len;
                    err_next   = 1'b0;
                end
            end
            MOVE: state_next = CHECK;
            CHECK: begin
                if (!fb_ok) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (cur_dwell == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_next   = cur_dwell;
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (cnt_q <= DWELL_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_next = DWELL_W'(cnt_q - DWELL_W'(1));
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (step_idx == len_q) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                step_next  = STEP_W'(step_idx + STEP_W'(1));
                state_next = MOVE;
            end
        end

        // Abort overrides everything outside IDLE and leaves err/step alone
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            done_next  = 1'b0;
            err_next   = err;
            step_next  = step_idx;
        end

        busy_next = (state_next != IDLE);

        // Forward a same-cycle table write so the first MOVE sees it
        tgt_next = route_state[step_next];
        if (we_ok && (cfg_addr == step_next)) begin
            tgt_next = cfg_state;
        end

        if (state_next == MOVE) begin
            t0_next = tgt_next;
            t1_next = tgt_next;
            t2_next = tgt_next;
            t3_next = tgt_next;
        end else begin
            t0_next = 2'd0;
            t1_next = 2'd1;
            t2_next = 2'd2;
            t3_next = 2'd3;
        end
    end

endmodule

// File: tb/tb_fsm_oe4s_sequencer.sv
// Bench for fsm_oe4s_sequencer: a behavioural 4-state FSM is driven by the
// t<y>x selects and feeds back one-hot state; expected done/err events are
// queued by the stimulus and consumed by an independent monitor.
module tb_fsm_oe4s_sequencer;

    typedef struct {
        bit       is_done;
        int       step;
        int       latency;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_state;
    logic [3:0] cfg_dwell;
    logic [2:0] route_len;
    logic       start, abort;
    logic       st0, st1, st2, st3;
    logic [1:0] t0x, t1x, t2x, t3x;
    logic       busy, done, err;
    logic [2:0] step_idx;

    logic [1:0] fsm_q = 2'd0;
    logic       force_fb = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         move_cyc = 0;
    bit         prev_busy = 1'b0;
    bit         prev_err = 1'b0;
    exp_t       exp_q[$];

    fsm_oe4s_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_state(cfg_state), .cfg_dwell(cfg_dwell), .route_len(route_len),
        .start(start), .abort(abort),
        .st0(st0), .st1(st1), .st2(st2), .st3(st3),
        .t0x(t0x), .t1x(t1x), .t2x(t2x), .t3x(t3x),
        .busy(busy), .done(done), .err(err), .step_idx(step_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driven FSM model: state y follows t<y>x each cycle
    always @(posedge clk) begin
        case (fsm_q)
            2'd0:    fsm_q <= t0x;
            2'd1:    fsm_q <= t1x;
            2'd2:    fsm_q <= t2x;
            default: fsm_q <= t3x;
        endcase
    end

    always_comb begin
        if (force_fb) {st3, st2, st1, st0} = 4'b0011;
        else          {st3, st2, st1, st0} = 4'b0001 << fsm_q;
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: consumes one queued expectation per done pulse or err rise
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (busy && !prev_busy) move_cyc = cyc;
            if (done || (err && !prev_err)) begin
                check("done_err_exclusive", int'(done && err), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_done", int'(done), int'(e.is_done));
                    check("event_step", int'(step_idx), e.step);
                    check("event_latency", cyc - move_cyc, e.latency);
                end
            end
            prev_busy = busy;
            prev_err  = err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int s, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_state = 2'(s);
        cfg_dwell = 4'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic expect_event(input bit is_done, input int step, input int lat);
        exp_t e;
        e.is_done = is_done;
        e.step    = step;
        e.latency = lat;
        exp_q.push_back(e);
    endtask

    // Pulse start; returns positioned in the MOVE cycle
    task automatic kick(input int len);
        route_len = 3'(len);
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles from now until idle, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_t0x"}, int'(t0x), 0);
        check({tag, "_t1x"}, int'(t1x), 1);
        check({tag, "_t2x"}, int'(t2x), 2);
        check({tag, "_t3x"}, int'(t3x), 3);
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_state = '0; cfg_dwell = '0;
        route_len = '0; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_step", int'(step_idx), 0);
        check_hold("rst");
        rst = 1'b0;
        tick();

        // Four zero-dwell steps S1,S2,S3,S0
        write_entry(0, 1, 0);
        write_entry(1, 2, 0);
        write_entry(2, 3, 0);
        write_entry(3, 0, 0);
        expect_event(1'b1, 3, 8);
        kick(3);
        check("move_t2x", int'(t2x), 1);
        wait_idle(n);
        check("route4_busy_cycles", n, 8);
        check("route4_fsm_final", int'(fsm_q), 0);
        check("route4_err", int'(err), 0);
        tick();

        // Single step with dwell 3
        write_entry(0, 2, 3);
        expect_event(1'b1, 0, 5);
        kick(0);
        wait_idle(n);
        check("dwell3_busy_cycles", n, 5);
        check("dwell3_fsm_final", int'(fsm_q), 2);
        tick();

        // Corrupt multi-hot feedback
        write_entry(0, 1, 0);
        force_fb = 1'b1;
        expect_event(1'b0, 0, 2);
        kick(0);
        wait_idle(n);
        check("badfb_busy_cycles", n, 2);
        check("badfb_err", int'(err), 1);
        check("badfb_done", int'(done), 0);
        force_fb = 1'b0;
        tick();
        check("badfb_err_sticky", int'(err), 1);
        expect_event(1'b1, 0, 2);
        kick(0);
        check("restart_clears_err", int'(err), 0);
        wait_idle(n);
        tick();

        // Abort in the DWELL of step 1
        write_entry(0, 1, 0);
        write_entry(1, 2, 5);
        kick(2);
        repeat (5) tick();
        check("pre_abort_step", int'(step_idx), 1);
        check("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        check("abort_step_hold", int'(step_idx), 1);
        check_hold("abort");
        tick();

        // Table write while busy is ignored
        write_entry(0, 2, 3);
        expect_event(1'b1, 0, 5);
        kick(0);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_state = 2'd1; cfg_dwell = 4'd0;
        tick();
        cfg_we = 1'b0;
        wait_idle(n);
        check("busy_write_run_cycles", n + 1, 5);
        tick();
        expect_event(1'b1, 0, 5);
        kick(0);
        wait_idle(n);
        check("rerun_old_entry_cycles", n, 5);
        check("rerun_old_entry_fsm", int'(fsm_q), 2);
        tick();

        // Async reset during MOVE clears outputs and table
        write_entry(0, 3, 2);
        kick(0);
        check("pre_rst_move_t1x", int'(t1x), 3);
        rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_step", int'(step_idx), 0);
        check("async_rst_done", int'(done), 0);
        check_hold("async_rst");
        tick();
        rst = 1'b0;
        tick();
        expect_event(1'b1, 0, 2);
        kick(0);
        check("cleared_entry_t3x", int'(t3x), 0);
        wait_idle(n);
        check("cleared_entry_fsm", int'(fsm_q), 0);
        tick();
        // Self-loop target 0 from state 0
        expect_event(1'b1, 0, 2);
        kick(0);
        wait_idle(n);
        check("selfloop_cycles", n, 2);

        repeat (4) tick();
        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
